// File: rtl/solver_feeder_pkg.sv
// Shared definitions for the solver feeder: FSM state encoding, header
// field offsets and result word layout.
package solver_feeder_pkg;

  // Feeder sequencing states.
  typedef enum logic [2:0] {
    ST_HEADER  = 3'd0,
    ST_LOAD_RE = 3'd1,
    ST_LOAD_IM = 3'd2,
    ST_START   = 3'd3,
    ST_WAIT    = 3'd4,
    ST_EMIT    = 3'd5
  } state_t;

  // Header word layout: [15:0] iteration limit, [16 +: LIMB_INDEX_BITS] limb count.
  localparam int HDR_ITER_LIM_LSB  = 0;
  localparam int HDR_NUM_LIMBS_LSB = 16;
  localparam int ITER_BITS         = 16;

  // Solver reports this count when the iteration limit was reached.
  localparam logic [15:0] ITER_LIMIT_HIT = 16'hFFFF;

  // Result word layout: {tag, iteration_count}.
  localparam int RES_COUNT_LSB = 0;
  localparam int RES_TAG_LSB   = 16;

endpackage

// File: rtl/solver_feeder_if.sv
// Bundle of all non-clock signals between the feeder and its environment
// (job word stream, result stream, solver register-file/control side).
//   master : the feeder itself
//   slave  : job source, result sink and solver lane
interface solver_feeder_if #(
  parameter int LIMB_INDEX_BITS = 6,
  parameter int LIMB_BITS       = 32,
  parameter int TAG_BITS        = 16
);
  // Job word stream.
  logic                       in_valid;
  logic                       in_ready;
  logic [LIMB_BITS-1:0]       in_data;
  // Result stream.
  logic                       res_valid;
  logic                       res_ready;
  logic [TAG_BITS+15:0]       res_data;
  // Solver programming side.
  logic                       wr_en;
  logic                       wr_ind;
  logic [LIMB_INDEX_BITS-1:0] wr_limb;
  logic [LIMB_BITS-1:0]       wr_data;
  logic                       wr_num_limbs_en;
  logic [LIMB_INDEX_BITS-1:0] num_limbs_data;
  logic                       wr_iter_lim_en;
  logic [15:0]                iter_lim_data;
  logic                       start;
  logic                       out_ready;
  logic [15:0]                iteration_count;
  // Status.
  logic                       busy;
  logic                       hdr_err;

  modport master (
    input  in_valid, in_data, res_ready, out_ready, iteration_count,
    output in_ready, res_valid, res_data, wr_en, wr_ind, wr_limb, wr_data,
           wr_num_limbs_en, num_limbs_data, wr_iter_lim_en, iter_lim_data,
           start, busy, hdr_err
  );

  modport slave (
    output in_valid, in_data, res_ready, out_ready, iteration_count,
    input  in_ready, res_valid, res_data, wr_en, wr_ind, wr_limb, wr_data,
           wr_num_limbs_en, num_limbs_data, wr_iter_lim_en, iter_lim_data,
           start, busy, hdr_err
  );

endinterface

// File: rtl/solver_feeder.sv
// Job loader for one Mandelbrot/Burning-Ship solver lane.
// Accepts a header word (limb count + iteration limit), then the c_re limbs
// and c_im limbs most-significant first, writes them into the solver's c
// register file, pulses start, waits for out_ready and returns
// {tag, iteration_count} on the result stream.
// Ports:
//   clock, reset : clock and synchronous active-high reset
//   bus (master) : job stream, result stream, solver programming/handshake,
//                  busy and sticky hdr_err status
module solver_feeder
  import solver_feeder_pkg::*;
#(
  parameter int LIMB_INDEX_BITS = 6,
  parameter int LIMB_BITS       = 32,
  parameter int TAG_BITS        = 16
) (
  input  logic            clock,
  input  logic            reset,
  solver_feeder_if.master bus
);

  localparam logic [LIMB_INDEX_BITS-1:0] LIMB_ZERO = {LIMB_INDEX_BITS{1'b0}};
  localparam logic [LIMB_INDEX_BITS-1:0] LIMB_ONE  = {{(LIMB_INDEX_BITS-1){1'b0}}, 1'b1};
  localparam logic [TAG_BITS-1:0]        TAG_ONE   = {{(TAG_BITS-1){1'b0}}, 1'b1};

  state_t                     state_r;
  logic [LIMB_INDEX_BITS-1:0] cnt_r;
  logic [LIMB_INDEX_BITS-1:0] num_limbs_r;
  logic [ITER_BITS-1:0]       iter_lim_r;
  logic [TAG_BITS-1:0]        tag_r;
  logic                       in_ready_r;
  logic                       res_valid_r;
  logic [TAG_BITS+15:0]       res_data_r;
  logic                       wr_en_r;
  logic                       wr_ind_r;
  logic [LIMB_INDEX_BITS-1:0] wr_limb_r;
  logic [LIMB_BITS-1:0]       wr_data_r;
  logic                       wr_num_limbs_en_r;
  logic                       wr_iter_lim_en_r;
  logic                       start_r;
  logic                       busy_r;
  logic                       hdr_err_r;

  logic                       accept_s;
  logic [LIMB_INDEX_BITS-1:0] hdr_num_limbs_s;
  logic [ITER_BITS-1:0]       hdr_iter_lim_s;

  // A word is consumed only when the registered in_ready is high.
  assign accept_s        = bus.in_valid && in_ready_r;
  assign hdr_num_limbs_s = bus.in_data[HDR_NUM_LIMBS_LSB +: LIMB_INDEX_BITS];
  assign hdr_iter_lim_s  = bus.in_data[HDR_ITER_LIM_LSB +: ITER_BITS];

  // Job sequencing FSM with all outputs registered.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r           <= ST_HEADER;
      cnt_r             <= LIMB_ZERO;
      num_limbs_r       <= LIMB_ZERO;
      iter_lim_r        <= 16'h0000;
      tag_r             <= {TAG_BITS{1'b0}};
      in_ready_r        <= 1'b0;
      res_valid_r       <= 1'b0;
      res_data_r        <= {(TAG_BITS+16){1'b0}};
      wr_en_r           <= 1'b0;
      wr_ind_r          <= 1'b0;
      wr_limb_r         <= LIMB_ZERO;
      wr_data_r         <= {LIMB_BITS{1'b0}};
      wr_num_limbs_en_r <= 1'b0;
      wr_iter_lim_en_r  <= 1'b0;
      start_r           <= 1'b0;
      busy_r            <= 1'b0;
      hdr_err_r         <= 1'b0;
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      wr_en_r           <= 1'b0;
      wr_num_limbs_en_r <= 1'b0;
      wr_iter_lim_en_r  <= 1'b0;
      start_r           <= 1'b0;
      case (state_r)
        ST_HEADER: begin
          in_ready_r <= 1'b1;
          if (accept_s) begin
            if (hdr_num_limbs_s == LIMB_ZERO) begin
              // Empty job: drop the word and flag it, keep waiting for a header.
              hdr_err_r <= 1'b1;
            end else begin
              num_limbs_r       <= hdr_num_limbs_s;
              iter_lim_r        <= hdr_iter_lim_s;
              wr_num_limbs_en_r <= 1'b1;
              wr_iter_lim_en_r  <= 1'b1;
              cnt_r             <= hdr_num_limbs_s - LIMB_ONE;
              busy_r            <= 1'b1;
              state_r           <= ST_LOAD_RE;
            end
          end
        end
        ST_LOAD_RE, ST_LOAD_IM: begin
          if (accept_s) begin
            wr_en_r   <= 1'b1;
            wr_ind_r  <= (state_r == ST_LOAD_IM);
            wr_limb_r <= cnt_r;
            wr_data_r <= bus.in_data;
            if (cnt_r == LIMB_ZERO) begin
              cnt_r <= num_limbs_r - LIMB_ONE;
              if (state_r == ST_LOAD_IM) begin
                // Drop in_ready together with leaving the load phase so the
                // next word waits for the following job.
                in_ready_r <= 1'b0;
                state_r    <= ST_START;
              end else begin
                state_r <= ST_LOAD_IM;
              end
            end else begin
              cnt_r <= cnt_r - LIMB_ONE;
            end
          end
        end
        ST_START: begin
          start_r <= 1'b1;
          state_r <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.out_ready) begin
            res_data_r[RES_TAG_LSB +: TAG_BITS]    <= tag_r;
            res_data_r[RES_COUNT_LSB +: ITER_BITS] <= bus.iteration_count;
            res_valid_r                            <= 1'b1;
            state_r                                <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (bus.res_ready) begin
            res_valid_r <= 1'b0;
            tag_r       <= tag_r + TAG_ONE;
            busy_r      <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= ST_HEADER;
          end
        end
        default: begin
          in_ready_r  <= 1'b0;
          res_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          state_r     <= ST_HEADER;
        end
      endcase
    end
  end

  assign bus.in_ready        = in_ready_r;
  assign bus.res_valid       = res_valid_r;
  assign bus.res_data        = res_data_r;
  assign bus.wr_en           = wr_en_r;
  assign bus.wr_ind          = wr_ind_r;
  assign bus.wr_limb         = wr_limb_r;
  assign bus.wr_data         = wr_data_r;
  assign bus.wr_num_limbs_en = wr_num_limbs_en_r;
  assign bus.num_limbs_data  = num_limbs_r;
  assign bus.wr_iter_lim_en  = wr_iter_lim_en_r;
  assign bus.iter_lim_data   = iter_lim_r;
  assign bus.start           = start_r;
  assign bus.busy            = busy_r;
  assign bus.hdr_err         = hdr_err_r;

endmodule

// File: tb/tb_solver_feeder.sv
// Scoreboard bench for solver_feeder: the driver pushes expected config,
// limb writes and results into queues; a monitor pops and compares them as
// the DUT presents them; a small solver model answers start pulses.
module tb_solver_feeder;
  import solver_feeder_pkg::*;

  localparam int LIB = 6;
  localparam int LB  = 32;
  localparam int TGB = 16;

  typedef struct packed {
    logic       ind;
    logic [5:0] limb;
    logic [31:0] data;
  } wr_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  solver_feeder_if #(.LIMB_INDEX_BITS(LIB), .LIMB_BITS(LB), .TAG_BITS(TGB)) bus ();
  solver_feeder #(.LIMB_INDEX_BITS(LIB), .LIMB_BITS(LB), .TAG_BITS(TGB)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clock) cyc <= cyc + 1;

  wr_t         exp_wr_q[$];
  logic [21:0] exp_cfg_q[$];
  logic [31:0] exp_res_q[$];
  logic [15:0] solver_q[$];
  int          starts_seen = 0;
  int          starts_exp  = 0;
  bit          consec_mode = 1'b0;
  logic [15:0] exp_tag     = 16'd0;
  logic [31:0] re_a[8];
  logic [31:0] im_a[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compare every strobe/result the DUT presents against the queues.
  logic        prev_v = 1'b0;
  logic        prev_r = 1'b0;
  logic [31:0] prev_d = 32'd0;
  int          last_evt = 0;
  int          last_wr  = 0;
  int          or_cyc   = 0;
  initial begin : monitor
    logic [21:0] e;
    wr_t         w;
    logic [31:0] r;
    forever begin
      @(negedge clock);
      if (bus.wr_num_limbs_en || bus.wr_iter_lim_en) begin
        if (exp_cfg_q.size() == 0) begin
          check("cfg_unexpected", 32'(bus.wr_num_limbs_en | bus.wr_iter_lim_en), 32'd0);
        end else begin
          e = exp_cfg_q.pop_front();
          check("cfg_both_strobes", 32'({bus.wr_num_limbs_en, bus.wr_iter_lim_en}), 32'd3);
          check("cfg_num_limbs", 32'(bus.num_limbs_data), 32'(e[21:16]));
          check("cfg_iter_lim", 32'(bus.iter_lim_data), 32'(e[15:0]));
        end
        last_evt = cyc;
      end
      if (bus.wr_en) begin
        if (consec_mode) check("wr_consecutive", 32'(cyc - last_evt), 32'd1);
        if (exp_wr_q.size() == 0) begin
          check("wr_unexpected", 32'(bus.wr_en), 32'd0);
        end else begin
          w = exp_wr_q.pop_front();
          check("wr_ind", 32'(bus.wr_ind), 32'(w.ind));
          check("wr_limb", 32'(bus.wr_limb), 32'(w.limb));
          check("wr_data", bus.wr_data, w.data);
        end
        last_evt = cyc;
        last_wr  = cyc;
      end
      if (bus.start) begin
        starts_seen++;
        check("start_after_last_wr", 32'(cyc - last_wr), 32'd1);
      end
      if (bus.out_ready) or_cyc = cyc;
      if (bus.res_valid) begin
        check("in_ready_low_in_emit", 32'(bus.in_ready), 32'd0);
        if (!prev_v) check("res_latency", 32'(cyc - or_cyc), 32'd1);
        else if (!prev_r) check("res_data_stable", bus.res_data, prev_d);
        if (bus.res_ready) begin
          if (exp_res_q.size() == 0) begin
            check("res_unexpected", 32'(bus.res_valid), 32'd0);
          end else begin
            r = exp_res_q.pop_front();
            check("res_data", bus.res_data, r);
          end
        end
      end
      prev_v = bus.res_valid;
      prev_r = bus.res_ready;
      prev_d = bus.res_data;
    end
  end

  // Solver model: out_ready pulses 50 cycles after each start.
  initial begin : solver_model
    logic [15:0] c;
    bus.out_ready       = 1'b0;
    bus.iteration_count = 16'd0;
    forever begin
      @(negedge clock);
      if (bus.start) begin
        if (solver_q.size() == 0) begin
          check("start_unexpected", 32'(bus.start), 32'd0);
          c = 16'd0;
        end else begin
          c = solver_q.pop_front();
        end
        repeat (50) @(posedge clock);
        #1;
        bus.out_ready       = 1'b1;
        bus.iteration_count = c;
        @(posedge clock);
        #1;
        bus.out_ready = 1'b0;
      end
    end
  end

  task automatic send_word(input logic [31:0] w, input int gap);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    do begin
      @(negedge clock);
      n++;
    end while (!bus.in_ready && n < 300);
    if (!bus.in_ready) begin
      check("in_ready_timeout", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clock);
    #1;
    if (gap > 0) begin
      bus.in_valid = 1'b0;
      repeat (gap) @(posedge clock);
      #1;
    end
  endtask

  task automatic push_wr(input logic ind, input int limb, input logic [31:0] d);
    wr_t w;
    w.ind  = ind;
    w.limb = 6'(limb);
    w.data = d;
    exp_wr_q.push_back(w);
  endtask

  task automatic run_job(input int n, input int iter, input logic [15:0] count,
                         input int gap, input bit hold);
    int k;
    exp_cfg_q.push_back({6'(n), 16'(iter)});
    for (k = 0; k < n; k++) push_wr(1'b0, n - 1 - k, re_a[k]);
    for (k = 0; k < n; k++) push_wr(1'b1, n - 1 - k, im_a[k]);
    solver_q.push_back(count);
    exp_res_q.push_back({exp_tag, count});
    exp_tag = exp_tag + 16'd1;
    starts_exp++;
    if (hold) bus.res_ready = 1'b0;
    send_word({10'd0, 6'(n), 16'(iter)}, gap);
    for (k = 0; k < n; k++) send_word(re_a[k], gap);
    for (k = 0; k < n; k++) send_word(im_a[k], gap);
    bus.in_valid = 1'b0;
    if (hold) begin
      k = 0;
      do begin
        @(negedge clock);
        k++;
      end while (!bus.res_valid && k < 500);
      check("hold_res_valid_seen", 32'(bus.res_valid), 32'd1);
      repeat (9) @(negedge clock);
      @(posedge clock);
      #1;
      bus.res_ready = 1'b1;
      @(negedge clock);
      @(negedge clock);
      check("in_ready_after_accept", 32'(bus.in_ready), 32'd1);
      check("res_valid_after_accept", 32'(bus.res_valid), 32'd0);
    end
    k = 0;
    while (exp_res_q.size() != 0 && k < 600) begin
      @(negedge clock);
      k++;
    end
    check("job_done", 32'(exp_res_q.size()), 32'd0);
    @(posedge clock);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
    check({tag, "_res_valid"}, 32'(bus.res_valid), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_hdr_err"}, 32'(bus.hdr_err), 32'd0);
    check({tag, "_strobes"}, 32'({bus.wr_en, bus.wr_num_limbs_en, bus.wr_iter_lim_en, bus.start}), 32'd0);
    check({tag, "_res_data"}, bus.res_data, 32'd0);
    check({tag, "_wr_data"}, bus.wr_data, 32'd0);
    check({tag, "_cfg_data"}, 32'({bus.num_limbs_data, bus.iter_lim_data}), 32'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  initial begin : driver
    bus.in_valid  = 1'b0;
    bus.in_data   = 32'd0;
    bus.res_ready = 1'b1;
    reset         = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check_idle_outputs("reset");
    reset = 1'b0;
    @(posedge clock);
    #1;
    check("header_in_ready", 32'(bus.in_ready), 32'd1);

    // Job 1: N=2, back-to-back words, tag 0.
    re_a[0] = 32'hA; re_a[1] = 32'hB;
    im_a[0] = 32'hC; im_a[1] = 32'hD;
    consec_mode = 1'b1;
    run_job(2, 100, 16'd37, 0, 1'b0);
    consec_mode = 1'b0;

    // Job 2: tag 1.
    re_a[0] = 32'h1111_0001; re_a[1] = 32'h2222_0002;
    im_a[0] = 32'h3333_0003; im_a[1] = 32'h4444_0004;
    run_job(2, 500, 16'd5, 0, 1'b0);

    // Empty header: dropped, flagged, no strobes.
    send_word(32'hFFC0_1234, 0);
    bus.in_valid = 1'b0;
    check("hdr_err_set", 32'(bus.hdr_err), 32'd1);
    check("hdr_err_not_busy", 32'(bus.busy), 32'd0);
    repeat (3) @(posedge clock);
    #1;
    check("hdr_err_in_ready", 32'(bus.in_ready), 32'd1);

    // N=1 job after the bad header: tag 2.
    re_a[0] = 32'h0000_5555;
    im_a[0] = 32'h0000_AAAA;
    run_job(1, 7, 16'd3, 0, 1'b0);

    // N=3 with in_valid toggling: tag 3.
    re_a[0] = 32'd1; re_a[1] = 32'd2; re_a[2] = 32'd3;
    im_a[0] = 32'd4; im_a[1] = 32'd5; im_a[2] = 32'd6;
    run_job(3, 1000, 16'd60, 1, 1'b0);

    // Result back-pressure with limit-hit count: tag 4.
    re_a[0] = 32'hDEAD_BEEF;
    im_a[0] = 32'hCAFE_F00D;
    run_job(1, 65535, ITER_LIMIT_HIT, 0, 1'b1);
    check("hdr_err_sticky", 32'(bus.hdr_err), 32'd1);

    // Reset while loading c_im.
    exp_cfg_q.push_back({6'd2, 16'd9});
    push_wr(1'b0, 1, 32'h0000_0101);
    push_wr(1'b0, 0, 32'h0000_0202);
    push_wr(1'b1, 1, 32'h0000_0303);
    send_word({10'd0, 6'd2, 16'd9}, 0);
    send_word(32'h0000_0101, 0);
    send_word(32'h0000_0202, 0);
    send_word(32'h0000_0303, 0);
    bus.in_valid = 1'b0;
    reset        = 1'b1;
    @(posedge clock);
    #1;
    check_idle_outputs("midjob_reset");
    reset   = 1'b0;
    exp_tag = 16'd0;
    @(posedge clock);
    #1;
    check("post_reset_in_ready", 32'(bus.in_ready), 32'd1);

    // Fresh job after reset: tag restarts at 0.
    re_a[0] = 32'h10; re_a[1] = 32'h20;
    im_a[0] = 32'h30; im_a[1] = 32'h40;
    run_job(2, 42, 16'd99, 0, 1'b0);

    repeat (5) @(posedge clock);
    #1;
    check("wr_queue_empty", 32'(exp_wr_q.size()), 32'd0);
    check("cfg_queue_empty", 32'(exp_cfg_q.size()), 32'd0);
    check("solver_queue_empty", 32'(solver_q.size()), 32'd0);
    check("start_count", 32'(starts_seen), 32'(starts_exp));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
